// File: rtl/audio_serial_tx.sv
// audio_serial_tx: stereo LJ / I2S / RJ serial transmitter with a one-deep pending sample buffer.
// Define APU_TX_UNDERRUN_MUTE_EN to send silence on underrun instead of repeating the last words.
module audio_serial_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int SCLK_DIV   = 8
) (
  input  logic                  MCLK_i,
  input  logic                  nRST_i,
  input  logic [1:0]            FMT_i,
  input  logic                  EN_i,
  input  logic [DATA_WIDTH-1:0] PDATA_LEFT_i,
  input  logic [DATA_WIDTH-1:0] PDATA_RIGHT_i,
  input  logic                  PDATA_VALID_i,
  output logic                  SCLK_o,
  output logic                  SDATA_o,
  output logic                  LRCLK_o,
  output logic                  UNDERRUN_o
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int BIT_W = $clog2(SLOT_WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_WIDTH - 1);

  logic [0:0]            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  slot_q, slot_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] bufLeft_q, bufLeft_d;
  logic [DATA_WIDTH-1:0] bufRight_q, bufRight_d;
  logic [DATA_WIDTH-1:0] wordLeft_q, wordLeft_d;
  logic [DATA_WIDTH-1:0] wordRight_q, wordRight_d;
  logic [1:0]            fmt_q, fmt_d;
  logic [SLOT_WIDTH-1:0] shift_q, shift_d;
  logic                  sclk_q, sclk_d;
  logic                  sdata_q, sdata_d;
  logic                  lrclk_q, lrclk_d;
  logic                  underrun_q, underrun_d;

  logic                  frameEnd;
  logic                  load;
  logic [SLOT_WIDTH-1:0] slotImg;

  // Full slot image, first transmitted bit in the MSB; format 11 falls into the LJ default.
  function automatic logic [SLOT_WIDTH-1:0] formatSlot(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [1:0]            f);
    logic [SLOT_WIDTH-1:0] img;
    case (f)
      2'b01:   img = SLOT_WIDTH'(w) << (SLOT_WIDTH - DATA_WIDTH - 1);
      2'b10:   img = {{(SLOT_WIDTH - DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
      default: img = SLOT_WIDTH'(w) << (SLOT_WIDTH - DATA_WIDTH);
    endcase
    return img;
  endfunction

  function automatic logic leftLevel(input logic [1:0] f);
    return (f == 2'b01) ? 1'b0 : 1'b1;
  endfunction

  assign frameEnd = (div_q == DIV_LAST) && (bit_q == BIT_LAST) && slot_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    slot_d      = slot_q;
    pending_d   = pending_q;
    bufLeft_d   = bufLeft_q;
    bufRight_d  = bufRight_q;
    wordLeft_d  = wordLeft_q;
    wordRight_d = wordRight_q;
    fmt_d       = fmt_q;
    shift_d     = shift_q;
    sclk_d      = sclk_q;
    sdata_d     = sdata_q;
    lrclk_d     = lrclk_q;
    underrun_d  = 1'b0;
    load        = 1'b0;
    slotImg     = shift_q;

    if (PDATA_VALID_i) begin
      bufLeft_d  = PDATA_LEFT_i;
      bufRight_d = PDATA_RIGHT_i;
      pending_d  = 1'b1;
    end

    if (state_q == ST_IDLE) begin
      if (EN_i && pending_q) begin
        state_d = ST_RUN;
        load    = 1'b1;
      end
    end else begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (bit_q == BIT_LAST) begin
          bit_d  = '0;
          slot_d = ~slot_q;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (frameEnd) begin
        if (EN_i) load = 1'b1;
        else      state_d = ST_IDLE;
      end
    end

    // The frame load happens on the edge that enters count 0; a same-cycle strobe bypasses the buffer.
    if (load) begin
      fmt_d     = FMT_i;
      pending_d = 1'b0;
      if (PDATA_VALID_i) begin
        wordLeft_d  = PDATA_LEFT_i;
        wordRight_d = PDATA_RIGHT_i;
      end else if (pending_q) begin
        wordLeft_d  = bufLeft_q;
        wordRight_d = bufRight_q;
      end else begin
        underrun_d = 1'b1;
`ifdef APU_TX_UNDERRUN_MUTE_EN
        wordLeft_d  = '0;
        wordRight_d = '0;
`else
        wordLeft_d  = wordLeft_q;
        wordRight_d = wordRight_q;
`endif
      end
    end

    if (state_d == ST_RUN) begin
      if (div_d == '0) begin
        sclk_d = 1'b0;
        if (bit_d == '0) begin
          slotImg = formatSlot(slot_d ? wordRight_d : wordLeft_d, fmt_d);
          lrclk_d = slot_d ? ~leftLevel(fmt_d) : leftLevel(fmt_d);
        end
        sdata_d = slotImg[SLOT_WIDTH-1];
        shift_d = slotImg << 1;
      end else if (div_d == DIV_HALF) begin
        sclk_d = 1'b1;
      end
    end else begin
      sclk_d  = 1'b1;
      sdata_d = 1'b0;
      lrclk_d = ~leftLevel(fmt_d);
    end
  end

  always_ff @(posedge MCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      slot_q      <= 1'b0;
      pending_q   <= 1'b0;
      bufLeft_q   <= '0;
      bufRight_q  <= '0;
      wordLeft_q  <= '0;
      wordRight_q <= '0;
      fmt_q       <= 2'b00;
      shift_q     <= '0;
      sclk_q      <= 1'b1;
      sdata_q     <= 1'b0;
      lrclk_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      slot_q      <= slot_d;
      pending_q   <= pending_d;
      bufLeft_q   <= bufLeft_d;
      bufRight_q  <= bufRight_d;
      wordLeft_q  <= wordLeft_d;
      wordRight_q <= wordRight_d;
      fmt_q       <= fmt_d;
      shift_q     <= shift_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      lrclk_q     <= lrclk_d;
      underrun_q  <= underrun_d;
    end
  end

  assign SCLK_o     = sclk_q;
  assign SDATA_o    = sdata_q;
  assign LRCLK_o    = lrclk_q;
  assign UNDERRUN_o = underrun_q;

endmodule

// File: tb/tb_audio_serial_tx.sv
// tb_audio_serial_tx: scoreboard bench for audio_serial_tx at default parameters.
// Expected frames are queued as samples are strobed and compared when the monitor reassembles a frame.
`timescale 1ns/1ps
module tb_audio_serial_tx;

  localparam int FRAME_CYC = 512;
  localparam int SCLK_DIV  = 8;

  logic        mclk = 1'b0;
  logic        nRst = 1'b1;
  logic [1:0]  fmt = 2'b00;
  logic        en = 1'b0;
  logic [23:0] pLeft = '0;
  logic [23:0] pRight = '0;
  logic        pValid = 1'b0;
  logic        sclk, sdata, lrclk, underrun;

  typedef struct {
    logic [63:0] data;
    logic [63:0] lr;
  } frameT;

  frameT expQ[$];
  int checks = 0;
  int errors = 0;

  logic [23:0] lastLeft = '0;
  logic [23:0] lastRight = '0;

  int bitIdx = 0;
  int highRun = 0;
  int frameStarts = 0;
  int underrunCount = 0;
  int cyc = 0;
  int startCyc = 0;
  logic contiguous = 1'b0;
  logic prevSclk = 1'b1;
  logic [63:0] dataBits = '0;
  logic [63:0] lrBits = '0;

  audio_serial_tx dut (
    .MCLK_i        (mclk),
    .nRST_i        (nRst),
    .FMT_i         (fmt),
    .EN_i          (en),
    .PDATA_LEFT_i  (pLeft),
    .PDATA_RIGHT_i (pRight),
    .PDATA_VALID_i (pValid),
    .SCLK_o        (sclk),
    .SDATA_o       (sdata),
    .LRCLK_o       (lrclk),
    .UNDERRUN_o    (underrun)
  );

  // 100 MHz master clock.
  always #5 mclk = ~mclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Slot bit k is placed at position 31-k so the first transmitted bit is the MSB.
  function automatic logic [31:0] slotBits(input logic [23:0] w, input logic [1:0] f);
    logic [31:0] s;
    logic b;
    s = '0;
    for (int k = 0; k < 32; k++) begin
      case (f)
        2'b01:   b = (k >= 1 && k <= 24) ? w[24-k] : 1'b0;
        2'b10:   b = (k < 8) ? w[23] : w[31-k];
        default: b = (k < 24) ? w[23-k] : 1'b0;
      endcase
      s[31-k] = b;
    end
    return s;
  endfunction

  task automatic pushFrame(input logic [23:0] l, input logic [23:0] r, input logic [1:0] f);
    frameT e;
    logic lv;
    lv = (f == 2'b01) ? 1'b0 : 1'b1;
    e.data = {slotBits(l, f), slotBits(r, f)};
    e.lr   = {{32{lv}}, {32{~lv}}};
    expQ.push_back(e);
    lastLeft  = l;
    lastRight = r;
  endtask

  task automatic pushUnderrun(input logic [1:0] f);
`ifdef APU_TX_UNDERRUN_MUTE_EN
    pushFrame(24'h0, 24'h0, f);
`else
    pushFrame(lastLeft, lastRight, f);
`endif
  endtask

  // Drives a one-cycle strobe starting at the current (negedge-aligned) time.
  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r);
    pLeft  = l;
    pRight = r;
    pValid = 1'b1;
    @(negedge mclk);
    pValid = 1'b0;
  endtask

  task automatic waitFrameStart();
    int start;
    int n;
    start = frameStarts;
    n = 0;
    while (frameStarts == start && n < 2000) begin
      @(negedge mclk);
      #1;
      n++;
    end
    checkOutput("frame_start_seen", 64'(frameStarts != start), 64'd1);
  endtask

  // Monitor: samples on the falling MCLK edge, captures a bit on every observed SCLK rise,
  // and treats a long SCLK-high stretch as idle so the next rise is bit 0 of a new frame.
  always @(negedge mclk) begin
    if (!nRst) begin
      bitIdx     = 0;
      highRun    = 0;
      prevSclk   = 1'b1;
      contiguous = 1'b0;
    end else begin
      cyc++;
      if (underrun) underrunCount++;
      if (sclk) highRun++;
      else      highRun = 0;
      if (highRun > SCLK_DIV) begin
        bitIdx     = 0;
        contiguous = 1'b0;
      end
      if (sclk && !prevSclk) begin
        if (bitIdx == 0) begin
          frameStarts++;
          if (contiguous) checkOutput("frame_period", 64'(cyc - startCyc), 64'(FRAME_CYC));
          startCyc   = cyc;
          contiguous = 1'b1;
        end
        dataBits[63-bitIdx] = sdata;
        lrBits[63-bitIdx]   = lrclk;
        bitIdx++;
        if (bitIdx == 64) begin
          bitIdx = 0;
          if (expQ.size() == 0) begin
            checkOutput("unexpected_frame", 64'(expQ.size()), 64'd1);
          end else begin
            frameT e;
            e = expQ.pop_front();
            checkOutput("frame_data", dataBits, e.data);
            checkOutput("frame_lrclk", lrBits, e.lr);
          end
        end
      end
      prevSclk = sclk;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int uc0;
    int startsAtF8;
    int n;

    #1 nRst = 1'b0;
    #1;
    checkOutput("reset_sclk", 64'(sclk), 64'd1);
    checkOutput("reset_sdata", 64'(sdata), 64'd0);
    checkOutput("reset_lrclk", 64'(lrclk), 64'd0);
    checkOutput("reset_underrun", 64'(underrun), 64'd0);
    repeat (3) @(negedge mclk);
    nRst = 1'b1;
    @(negedge mclk);

    // Frame 1: left-justified reference pattern.
    fmt = 2'b00;
    applyStimulus(24'hA5A5A5, 24'h123456);
    pushFrame(24'hA5A5A5, 24'h123456, 2'b00);
    en = 1'b1;
    waitFrameStart();

    // Frames 2-4: I2S, RJ with negative full scale, and format 11 acting as LJ.
    fmt = 2'b01;
    applyStimulus(24'hA5A5A5, 24'h123456);
    pushFrame(24'hA5A5A5, 24'h123456, 2'b01);
    waitFrameStart();
    fmt = 2'b10;
    applyStimulus(24'h800000, 24'h7FFFFE);
    pushFrame(24'h800000, 24'h7FFFFE, 2'b10);
    waitFrameStart();
    fmt = 2'b11;
    begin
      logic [23:0] rl, rr;
      rl = 24'($urandom());
      rr = 24'($urandom());
      applyStimulus(rl, rr);
      pushFrame(rl, rr, 2'b11);
    end
    waitFrameStart();

    // Frames 5-6: no strobes, two underruns.
    uc0 = underrunCount;
    pushUnderrun(2'b11);
    waitFrameStart();
    pushUnderrun(2'b11);
    waitFrameStart();
    checkOutput("underrun_pulses", 64'(underrunCount - uc0), 64'd2);

    // Frame 7: strobe lands on the last cycle before the boundary.
    fmt = 2'b00;
    repeat (507) @(negedge mclk);
    applyStimulus(24'h3C0FF1, 24'hC3F00E);
    pushFrame(24'h3C0FF1, 24'hC3F00E, 2'b00);
    waitFrameStart();
    checkOutput("no_underrun_boundary_strobe", 64'(underrunCount - uc0), 64'd2);

    fmt = 2'b01;
    applyStimulus(24'h5A5A5A, 24'h0F0F0F);
    pushFrame(24'h5A5A5A, 24'h0F0F0F, 2'b01);
    waitFrameStart();
    checkOutput("no_underrun_restrobe", 64'(underrunCount - uc0), 64'd2);

    // Frame 8 in flight: strobe, then disable mid-frame; the frame must finish and stop.
    startsAtF8 = frameStarts;
    applyStimulus(24'h13579B, 24'hFFFFFF);
    repeat (100) @(negedge mclk);
    en = 1'b0;
    repeat (700) @(negedge mclk);
    #1;
    checkOutput("no_frame_after_disable", 64'(frameStarts - startsAtF8), 64'd0);
    checkOutput("frame8_complete", 64'(expQ.size()), 64'd0);
    checkOutput("idle_sclk", 64'(sclk), 64'd1);
    checkOutput("idle_sdata", 64'(sdata), 64'd0);
    checkOutput("idle_lrclk_i2s", 64'(lrclk), 64'd1);

    // Re-enable: the pending strobe goes out, then reset during right-slot bit 10.
    en = 1'b1;
    pushFrame(24'h13579B, 24'hFFFFFF, 2'b01);
    n = 0;
    while (bitIdx != 43 && n < 2000) begin
      @(negedge mclk);
      #1;
      n++;
    end
    checkOutput("reached_right_bit10", 64'(bitIdx), 64'd43);
    #1 nRst = 1'b0;
    #1;
    checkOutput("midframe_reset_sclk", 64'(sclk), 64'd1);
    checkOutput("midframe_reset_sdata", 64'(sdata), 64'd0);
    checkOutput("midframe_reset_lrclk", 64'(lrclk), 64'd0);
    checkOutput("midframe_reset_underrun", 64'(underrun), 64'd0);
    expQ.delete();
    repeat (3) @(negedge mclk);
    nRst = 1'b1;
    @(negedge mclk);
    #1;
    checkOutput("post_reset_sclk", 64'(sclk), 64'd1);
    checkOutput("post_reset_lrclk", 64'(lrclk), 64'd0);

    fmt = 2'b00;
    @(negedge mclk);
    applyStimulus(24'h2468AC, 24'hDB9753);
    pushFrame(24'h2468AC, 24'hDB9753, 2'b00);
    waitFrameStart();
    en = 1'b0;

    n = 0;
    while (expQ.size() != 0 && n < 1500) begin
      @(negedge mclk);
      n++;
    end
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
